// File: rtl/reg_file_alu.sv
// Eight-entry register file with two combinational read ports feeding a
// combinational eight-function ALU; writes are synchronous, reset is asynchronous.
module reg_file_alu #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WIDTH-1:0]  d,
    input  logic [ADDR_W-1:0] sel_w,
    input  logic [ADDR_W-1:0] sel_r1,
    input  logic [ADDR_W-1:0] sel_r2,
    input  logic [2:0]        op,
    output logic [WIDTH-1:0]  q1,
    output logic [WIDTH-1:0]  q2,
    output logic [WIDTH-1:0]  result,
    output logic              zero
);

    localparam int NUM_REGS = 1 << ADDR_W;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alu_op_e          alu_op;

    // NOTE: the array is built from flops, not a RAM macro, so clearing every
    // entry on reset is legal and guarantees the read ports never show X.
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (load) begin
            regs[sel_w] <= d;
        end
    end

    // No bypass: a same-cycle write becomes visible only after the edge.
    assign q1 = regs[sel_r1];
    assign q2 = regs[sel_r2];

    assign a      = q1;
    assign b      = q2;
    assign alu_op = alu_op_e'(op);

    // NOTE: result gets a default before the case so no latch can be inferred.
    always_comb begin
        result = '0;
        case (alu_op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_SHL:  result = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  result = {1'b0, a[WIDTH-1:1]};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_reg_file_alu.sv
// Directed self-checking bench for reg_file_alu: reset behaviour, every ALU op,
// wrap-around, write gating, read-during-write timing and asynchronous reset.
module tb_reg_file_alu;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] d;
    logic [2:0] sel_w;
    logic [2:0] sel_r1;
    logic [2:0] sel_r2;
    logic [2:0] op;
    logic [7:0] q1;
    logic [7:0] q2;
    logic [7:0] result;
    logic       zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    reg_file_alu #(.WIDTH(8), .ADDR_W(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .d      (d),
        .sel_w  (sel_w),
        .sel_r1 (sel_r1),
        .sel_r2 (sel_r2),
        .op     (op),
        .q1     (q1),
        .q2     (q2),
        .result (result),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a single write on the next rising edge and returns 1 ns after it.
    task automatic do_write(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        load  = 1'b1;
        sel_w = addr;
        d     = data;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        load   = 1'b0;
        d      = 8'h00;
        sel_w  = 3'd0;
        sel_r1 = 3'd3;
        sel_r2 = 3'd6;
        op     = 3'b000;
        #2;
        total_cnt++;
        if (q1 !== 8'h00) $display("FAIL reset_q1: got %h expected 00", q1);
        else pass_cnt++;
        total_cnt++;
        if (q2 !== 8'h00) $display("FAIL reset_q2: got %h expected 00", q2);
        else pass_cnt++;
        total_cnt++;
        if (result !== 8'h00 || zero !== 1'b1)
            $display("FAIL reset_add: got %h/%b expected 00/1", result, zero);
        else pass_cnt++;
        op = 3'b101;
        #1;
        total_cnt++;
        if (result !== 8'hFF || zero !== 1'b0)
            $display("FAIL reset_not: got %h/%b expected ff/0", result, zero);
        else pass_cnt++;
        // Writes attempted while reset is held must be ignored.
        @(negedge clk);
        load   = 1'b1;
        sel_w  = 3'd3;
        d      = 8'h77;
        @(posedge clk);
        #1;
        load = 1'b0;
        total_cnt++;
        if (q1 !== 8'h00) $display("FAIL reset_blocks_write: got %h expected 00", q1);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        op    = 3'b000;
    endtask

    task automatic test_alu_ops();
        logic [7:0] exp_tbl [8];
        exp_tbl[0] = 8'h12; exp_tbl[1] = 8'h0C; exp_tbl[2] = 8'h03; exp_tbl[3] = 8'h0F;
        exp_tbl[4] = 8'h0C; exp_tbl[5] = 8'hF0; exp_tbl[6] = 8'h1E; exp_tbl[7] = 8'h07;
        do_write(3'd0, 8'h0F);
        do_write(3'd1, 8'h03);
        sel_r1 = 3'd0;
        sel_r2 = 3'd1;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            #1;
            total_cnt++;
            if (result !== exp_tbl[i] || zero !== 1'b0)
                $display("FAIL alu_op%0d: got %h/%b expected %h/0", i, result, zero, exp_tbl[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap_and_equal();
        sel_r1 = 3'd1;
        sel_r2 = 3'd0;
        op     = 3'b001;
        #1;
        total_cnt++;
        if (result !== 8'hF4 || zero !== 1'b0)
            $display("FAIL sub_wrap: got %h/%b expected f4/0", result, zero);
        else pass_cnt++;
        sel_r1 = 3'd0;
        sel_r2 = 3'd0;
        op     = 3'b100;
        #1;
        total_cnt++;
        if (q1 !== 8'h0F || q2 !== 8'h0F)
            $display("FAIL same_reg_read: got %h,%h expected 0f,0f", q1, q2);
        else pass_cnt++;
        total_cnt++;
        if (result !== 8'h00 || zero !== 1'b1)
            $display("FAIL xor_equal: got %h/%b expected 00/1", result, zero);
        else pass_cnt++;
    endtask

    task automatic test_load_disable();
        @(negedge clk);
        load   = 1'b0;
        d      = 8'hAA;
        sel_w  = 3'd0;
        sel_r1 = 3'd0;
        repeat (4) @(posedge clk);
        #1;
        total_cnt++;
        if (q1 !== 8'h0F) $display("FAIL load_disable: got %h expected 0f", q1);
        else pass_cnt++;
    endtask

    task automatic test_add_overflow();
        do_write(3'd0, 8'hFF);
        do_write(3'd1, 8'hFF);
        sel_r1 = 3'd0;
        sel_r2 = 3'd1;
        op     = 3'b000;
        #1;
        total_cnt++;
        if (result !== 8'hFE || zero !== 1'b0)
            $display("FAIL add_overflow: got %h/%b expected fe/0", result, zero);
        else pass_cnt++;
    endtask

    task automatic test_read_during_write();
        sel_r1 = 3'd7;
        @(negedge clk);
        load  = 1'b1;
        sel_w = 3'd7;
        d     = 8'h55;
        #1;
        total_cnt++;
        if (q1 !== 8'h00) $display("FAIL rdw_before_edge: got %h expected 00", q1);
        else pass_cnt++;
        @(posedge clk);
        #1;
        load = 1'b0;
        total_cnt++;
        if (q1 !== 8'h55) $display("FAIL rdw_after_edge: got %h expected 55", q1);
        else pass_cnt++;
        do_write(3'd7, 8'h80);
        op = 3'b110;
        #1;
        total_cnt++;
        if (result !== 8'h00 || zero !== 1'b1)
            $display("FAIL shl_msb_out: got %h/%b expected 00/1", result, zero);
        else pass_cnt++;
        op = 3'b111;
        #1;
        total_cnt++;
        if (result !== 8'h40 || zero !== 1'b0)
            $display("FAIL shr: got %h/%b expected 40/0", result, zero);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_write(3'd2, 8'h3C);
        do_write(3'd4, 8'hC3);
        @(posedge clk);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel_r1 = 3'(2 * i);
            sel_r2 = 3'(2 * i + 1);
            #1;
            total_cnt++;
            if (q1 !== 8'h00 || q2 !== 8'h00)
                $display("FAIL async_reset_r%0d_r%0d: got %h,%h expected 00,00",
                         2 * i, 2 * i + 1, q1, q2);
            else pass_cnt++;
        end
        // Reset held across an edge with load asserted still wins.
        @(negedge clk);
        load   = 1'b1;
        sel_w  = 3'd2;
        d      = 8'h99;
        sel_r1 = 3'd2;
        @(posedge clk);
        #1;
        total_cnt++;
        if (q1 !== 8'h00) $display("FAIL reset_wins_edge: got %h expected 00", q1);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total_cnt++;
        if (q1 !== 8'h00) $display("FAIL release_no_edge: got %h expected 00", q1);
        else pass_cnt++;
        @(posedge clk);
        #1;
        load = 1'b0;
        total_cnt++;
        if (q1 !== 8'h99) $display("FAIL first_write_after_reset: got %h expected 99", q1);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_wrap_and_equal();
        test_load_disable();
        test_add_overflow();
        test_read_during_write();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
